// File: rtl/keyin_buf.sv
// Key event front end: synchronises and debounces the encoder output, then emits one strobe per press
// and shifts the key digit into a 32-bit entry register. Optional auto-repeat: KEYIN_BUF_REPEAT_EN.
module keyin_buf #(
    parameter int unsigned DB_CYCLES  = 1000,
    parameter int unsigned REP_DELAY  = 500000,
    parameter int unsigned REP_PERIOD = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_in,
    input  logic [3:0]  key_val,
    input  logic        clr,
    output logic        key_pulse,
    output logic [3:0]  key_code,
    output logic [31:0] value,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  sync1_q, sync2_q, prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pulse_q, busy_q;
    logic [3:0]  code_q, code_d;
    logic [31:0] value_q, value_d;

    logic        s_in;
    logic [3:0]  s_val;
    logic        changed;
    logic        accept;
    logic        rep_fire;
    logic        event_w;
    logic [3:0]  event_code;

    assign s_in    = sync2_q[4];
    assign s_val   = sync2_q[3:0];
    assign changed = (sync2_q != prev_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            code_q  <= '0;
            value_q <= '0;
        end else begin
            sync1_q <= {key_in, key_val};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= event_w;
            busy_q  <= (state_q != IDLE);
            code_q  <= code_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s_in) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!s_in) state_d = REL_WAIT;
            end
            REL_WAIT: begin
                if (s_in) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEYIN_BUF_REPEAT_EN
    logic [23:0] hold_q, hold_d;
    logic        phase_q, phase_d;
    logic [23:0] hold_lim;

    assign hold_lim = phase_q ? 24'(REP_PERIOD - 1) : 24'(REP_DELAY - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            phase_q <= phase_d;
        end
    end

    // Counter freezes in REL_WAIT; any (re)entry to HELD restarts the initial delay.
    always_comb begin
        hold_d   = hold_q;
        phase_d  = phase_q;
        rep_fire = 1'b0;
        if (state_q == HELD && state_d == HELD) begin
            if (hold_q == hold_lim) begin
                rep_fire = 1'b1;
                hold_d   = '0;
                phase_d  = 1'b1;
            end else begin
                hold_d = hold_q + 24'd1;
            end
        end else if (state_d == HELD) begin
            hold_d  = '0;
            phase_d = 1'b0;
        end
    end
`else
    localparam int unsigned unused_rep = REP_DELAY ^ REP_PERIOD;
    assign rep_fire = 1'b0;
`endif

    assign event_w    = accept | rep_fire;
    assign event_code = accept ? s_val : code_q;

    always_comb begin
        code_d  = event_w ? event_code : code_q;
        value_d = value_q;
        if (clr)
            value_d = '0;
        else if (event_w)
            value_d = {value_q[27:0], event_code};
    end

    assign key_pulse = pulse_q;
    assign key_code  = code_q;
    assign value     = value_q;
    assign busy      = busy_q;

endmodule
